// File: rtl/cr_tlvp_gen_pkg.sv
// rtl/cr_tlvp_gen_pkg.sv - shared types and header layout for the TLV stream transmitter
package cr_tlvp_gen_pkg;

    localparam int FIELD_W   = 8;
    localparam int TYPE_LSB  = 56;
    localparam int LEN_LSB   = 48;
    localparam int MODID_LSB = 40;
    localparam int SEQ_LSB   = 32;

    typedef struct packed {
        logic [63:0] tdata;
        logic        sot;
        logic        eot;
        logic        tlast;
    } tlv_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } tlv_state_t;

    // Header word: type/len/module_id/seq in the top 32 bits, low half zero.
    function automatic logic [63:0] build_hdr(
        input logic [7:0] typ,
        input logic [7:0] len,
        input logic [7:0] modid,
        input logic [7:0] seq
    );
        logic [63:0] h;
        h = '0;
        h[TYPE_LSB  +: FIELD_W] = typ;
        h[LEN_LSB   +: FIELD_W] = len;
        h[MODID_LSB +: FIELD_W] = modid;
        h[SEQ_LSB   +: FIELD_W] = seq;
        return h;
    endfunction

endpackage

// File: rtl/cr_tlvp_gen_fifo.sv
// rtl/cr_tlvp_gen_fifo.sv - register-based first-word-fall-through FIFO of TLV words
module cr_tlvp_gen_fifo
    import cr_tlvp_gen_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int AEMPTY_VAL = 1,
    parameter int AFULL_VAL  = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_wr,
    input  tlv_word_t i_wdata,
    input  logic      i_rd,
    output tlv_word_t o_rdata,
    output logic      o_full,
    output logic      o_afull,
    output logic      o_empty,
    output logic      o_aempty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH  = DEPTH[AW:0];
    localparam logic [AW:0] C_AEMPTY = AEMPTY_VAL[AW:0];
    localparam logic [AW:0] C_AFULL  = AFULL_VAL[AW:0];

    tlv_word_t      r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;
    logic [AW:0]    w_free;

    assign w_push   = i_wr && !o_full;
    assign w_pop    = i_rd && !o_empty;
    assign w_free   = C_DEPTH - r_count;
    assign o_full   = (r_count == C_DEPTH);
    assign o_afull  = (w_free <= C_AFULL);
    assign o_empty  = (r_count == '0);
    assign o_aempty = (r_count <= C_AEMPTY);
    // Head is forced to zero when empty so stale storage never shows on the outputs.
    assign o_rdata  = o_empty ? '0 : r_mem[r_rptr];

    // Storage write; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cr_tlvp_gen.sv
// rtl/cr_tlvp_gen.sv - TLV stream transmitter: header generation, payload delimiting, output FIFO
module cr_tlvp_gen
    import cr_tlvp_gen_pkg::*;
#(
    parameter int N_OF_ENTRIES    = 16,
    parameter int N_OF_AEMPTY_VAL = 1,
    parameter int N_OF_AFULL_VAL  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  module_id,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_type,
    input  logic [7:0]  cmd_len,
    input  logic        cmd_last,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic [63:0] pl_data,
    input  logic        ob_rd,
    output logic        ob_empty,
    output logic        ob_aempty,
    output logic [63:0] ob_tdata,
    output logic        ob_sot,
    output logic        ob_eot,
    output logic        ob_tlast,
    output logic        tlv_error
);

    tlv_state_t r_state;
    tlv_state_t w_next;
    logic [7:0] r_type;
    logic [7:0] r_len;
    logic       r_last;
    logic [7:0] r_cnt;
    logic [7:0] r_seq;
    logic       r_err;
    logic       r_run;
    logic       w_wr;
    tlv_word_t  w_wdata;
    tlv_word_t  w_head;
    logic       w_full;
    logic       w_afull;
    logic       w_empty;
    logic       w_aempty;

    cr_tlvp_gen_fifo #(
        .DEPTH      (N_OF_ENTRIES),
        .AEMPTY_VAL (N_OF_AEMPTY_VAL),
        .AFULL_VAL  (N_OF_AFULL_VAL)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_wr     (w_wr),
        .i_wdata  (w_wdata),
        .i_rd     (ob_rd),
        .o_rdata  (w_head),
        .o_full   (w_full),
        .o_afull  (w_afull),
        .o_empty  (w_empty),
        .o_aempty (w_aempty)
    );

    assign ob_empty  = w_empty;
    assign ob_aempty = w_aempty;
    assign ob_tdata  = w_head.tdata;
    assign ob_sot    = w_head.sot;
    assign ob_eot    = w_head.eot;
    assign ob_tlast  = w_head.tlast;
    assign tlv_error = r_err;

    // Next-state, handshakes and FIFO write word (header or payload).
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        pl_ready  = 1'b0;
        w_wr      = 1'b0;
        w_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = r_run && !w_afull;
                if (cmd_valid && r_run && !w_afull) w_next = ST_HDR;
            end
            ST_HDR: begin
                if (!w_full) begin
                    w_wr          = 1'b1;
                    w_wdata.tdata = build_hdr(r_type, r_len, module_id, r_seq);
                    w_wdata.sot   = 1'b1;
                    w_wdata.eot   = (r_len == 8'd0);
                    w_wdata.tlast = r_last && (r_len == 8'd0);
                    w_next        = (r_len == 8'd0) ? ST_IDLE : ST_PAY;
                end
            end
            ST_PAY: begin
                pl_ready = !w_full;
                if (pl_valid && !w_full) begin
                    w_wr          = 1'b1;
                    w_wdata.tdata = pl_data;
                    w_wdata.eot   = (r_cnt == 8'd1);
                    w_wdata.tlast = r_last && (r_cnt == 8'd1);
                    if (r_cnt == 8'd1) w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, command latch, payload counter and header sequence number.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_type  <= '0;
            r_len   <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_seq   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && cmd_ready && cmd_valid) begin
                r_type <= cmd_type;
                r_len  <= cmd_len;
                r_last <= cmd_last;
            end
            if (r_state == ST_HDR && w_wr) begin
                r_seq <= r_seq + 8'd1;
                r_cnt <= r_len;
            end
            if (r_state == ST_PAY && w_wr) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // Keeps cmd_ready low through reset and the first cycle after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_run <= 1'b0;
        else     r_run <= 1'b1;
    end

    // Sticky error on a pop attempt against an empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_err <= 1'b0;
        else if (ob_rd && w_empty)  r_err <= 1'b1;
    end

endmodule

// File: tb/tb_cr_tlvp_gen.sv
// tb/tb_cr_tlvp_gen.sv - self-checking bench for cr_tlvp_gen
module tb_cr_tlvp_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  module_id = 8'h5A;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_type = '0;
    logic [7:0]  cmd_len = '0;
    logic        cmd_last = 1'b0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [63:0] pl_data = '0;
    logic        ob_rd = 1'b0;
    logic        ob_empty;
    logic        ob_aempty;
    logic [63:0] ob_tdata;
    logic        ob_sot;
    logic        ob_eot;
    logic        ob_tlast;
    logic        tlv_error;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [66:0] sb_q [$];
    logic [7:0]  seq_m = '0;
    int          pl_left = 0;
    logic        cur_last = 1'b0;
    logic        cmd_acc;
    logic        pl_acc;
    int          rd_mode = 0;
    int          n_acc;
    logic        got;

    cr_tlvp_gen dut (
        .clk       (clk),
        .rst       (rst),
        .module_id (module_id),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_len   (cmd_len),
        .cmd_last  (cmd_last),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .ob_rd     (ob_rd),
        .ob_empty  (ob_empty),
        .ob_aempty (ob_aempty),
        .ob_tdata  (ob_tdata),
        .ob_sot    (ob_sot),
        .ob_eot    (ob_eot),
        .ob_tlast  (ob_tlast),
        .tlv_error (tlv_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: score the head word, record handshakes, then update ob_rd after the edge.
    task automatic tick();
        logic [66:0] exp;
        @(negedge clk);
        cmd_acc = cmd_valid && cmd_ready;
        pl_acc  = pl_valid && pl_ready;
        if (ob_rd && !ob_empty) begin
            if (sb_q.size() > 0) exp = sb_q.pop_front();
            else                 exp = 'x;
            chk("sb_word", {ob_tdata, ob_sot, ob_eot, ob_tlast}, exp);
        end
        if (cmd_acc) begin
            sb_q.push_back({cmd_type, cmd_len, module_id, seq_m, 32'h0,
                            1'b1, cmd_len == 8'd0, cmd_last && (cmd_len == 8'd0)});
            seq_m    = seq_m + 8'd1;
            pl_left  = int'(cmd_len);
            cur_last = cmd_last;
        end
        if (pl_acc) begin
            sb_q.push_back({pl_data, 1'b0, pl_left == 1, cur_last && (pl_left == 1)});
            pl_left--;
        end
        @(posedge clk);
        #1;
        ob_rd = (rd_mode == 2) ? 1'b1 : (rd_mode == 1) ? !ob_empty : 1'b0;
    endtask

    task automatic offer_cmd(input logic [7:0] t, input logic [7:0] l, input logic last);
        cmd_type  = t;
        cmd_len   = l;
        cmd_last  = last;
        cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            got = cmd_acc;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", got, 1'b1);
    endtask

    task automatic offer_pl(input int target, input int budget, input logic [63:0] base);
        pl_valid = 1'b1;
        pl_data  = base + 64'(n_acc);
        for (int i = 0; i < budget && n_acc < target; i++) begin
            tick();
            if (pl_acc) begin
                n_acc++;
                pl_data = base + 64'(n_acc);
            end
        end
        pl_valid = 1'b0;
    endtask

    task automatic send_tlv(input logic [7:0] t, input logic [7:0] l, input logic last,
                            input logic [63:0] base);
        offer_cmd(t, l, last);
        n_acc = 0;
        if (l != 8'd0) begin
            offer_pl(int'(l), 600, base);
            chk("pl_count", 67'(n_acc), 67'(l));
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && !(sb_q.size() == 0 && ob_empty); i++) tick();
        chk("drained", {sb_q.size() == 0, ob_empty}, 2'b11);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_empty", {ob_empty, ob_aempty}, 2'b11);
        chk("rst_ready", {cmd_ready, pl_ready}, 2'b00);
        chk("rst_head", {ob_tdata, ob_sot, ob_eot, ob_tlast}, '0);
        chk("rst_err", tlv_error, 1'b0);
        sb_q.delete();
        seq_m = '0;
        pl_left = 0;
        cmd_valid = 1'b0;
        pl_valid = 1'b0;
        ob_rd = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        #2;
        do_reset();

        // 1: zero-length TLV with ob_rd held high; latency and pop-on-empty error
        rd_mode = 2;
        ob_rd = 1'b1;
        offer_cmd(8'h12, 8'h00, 1'b1);
        chk("lat_t1_empty", ob_empty, 1'b1);
        tick();
        chk("lat_t2_empty", ob_empty, 1'b0);
        chk("t1_head", {ob_tdata, ob_sot, ob_eot, ob_tlast}, {64'h12005A0000000000, 3'b111});
        wait_drain();
        chk("t1_err_set", tlv_error, 1'b1);

        // 2: two TLVs in one frame, gated reads
        rd_mode = 0;
        do_reset();
        rd_mode = 1;
        send_tlv(8'h21, 8'd3, 1'b0, 64'hA000_0000_0000_00A0);
        send_tlv(8'h22, 8'd2, 1'b1, 64'hD000_0000_0000_00D0);
        wait_drain();
        chk("t2_no_err", tlv_error, 1'b0);

        // 3: fill to full with no reads, then drain
        rd_mode = 0;
        tick();
        offer_cmd(8'h33, 8'd20, 1'b1);
        n_acc = 0;
        offer_pl(20, 40, 64'h3300_0000_0000_0000);
        chk("t3_acc_at_full", 67'(n_acc), 67'd15);
        chk("t3_full_flags", {ob_empty, ob_aempty, pl_ready, cmd_ready}, 4'b0000);
        rd_mode = 1;
        offer_pl(20, 200, 64'h3300_0000_0000_0000);
        chk("t3_acc_total", 67'(n_acc), 67'd20);
        wait_drain();

        // 4: pop while empty sets a sticky error
        rd_mode = 0;
        tick();
        chk("t4_pre", {ob_empty, tlv_error}, 2'b10);
        ob_rd = 1'b1;
        tick();
        chk("t4_err_set", tlv_error, 1'b1);
        rd_mode = 1;
        send_tlv(8'h44, 8'd2, 1'b1, 64'h4400_0000_0000_0001);
        wait_drain();
        chk("t4_err_sticky", tlv_error, 1'b1);

        // 5: reset in the middle of a TLV
        offer_cmd(8'h55, 8'd5, 1'b1);
        n_acc = 0;
        offer_pl(2, 40, 64'h5500_0000_0000_0000);
        do_reset();
        chk("t5_err_clr", tlv_error, 1'b0);
        rd_mode = 1;
        send_tlv(8'h77, 8'd1, 1'b1, 64'h7777_0000_0000_7777);
        wait_drain();

        // 6: sequence number wraps after 256 headers
        rd_mode = 0;
        do_reset();
        rd_mode = 1;
        for (int k = 0; k < 257; k++) begin
            send_tlv(8'h60, 8'd0, 1'b1, '0);
        end
        wait_drain();
        chk("t6_no_err", tlv_error, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
